matvec_stream_ctrl: RTL and testbench

MATVEC_STREAM_CTRL -- requirements
Module: matvec_stream_ctrl

---
 rtl/matvec_pkg.sv | 10 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/matvec_stream_ctrl.sv | 113 +++++++++++
 tb/tb_matvec_stream_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared state encoding and default parameters for the matrix-vector stream controller
package matvec_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_LANES      = 4;
  localparam int DEF_ROWS       = 3;
  localparam int DEF_PIPE_LAT   = 40;
  localparam int DEF_FIFO_DEPTH = 64;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count
// Ports: aclk/aresetn clock and async active-low reset; push/din write side;
//        pop/dout/empty read side (dout is the head, zero when empty); count entries held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/matvec_stream_ctrl.sv
// matvec_stream_ctrl: loads a matrix from AXI-Stream, feeds vectors to a fixed-latency core, queues results
// Ports: aclk/aresetn clock and async active-low reset; s_* matrix rows then vectors in (lane0 in LSBs);
//        m_* results out (row0 in LSBs); core_mat/core_load held matrix and completion pulse;
//        core_vec/core_vec_valid vector to the core; core_res core result; err_frame sticky short-frame flag
module matvec_stream_ctrl
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ROWS       = DEF_ROWS,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [LANES*DATA_WIDTH-1:0]        s_tdata,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic                               s_tlast,
  output logic [ROWS*OUT_WIDTH-1:0]          m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic [ROWS*LANES*DATA_WIDTH-1:0]   core_mat,
  output logic                               core_load,
  output logic [LANES*DATA_WIDTH-1:0]        core_vec,
  output logic                               core_vec_valid,
  input  logic [ROWS*OUT_WIDTH-1:0]          core_res,
  output logic                               err_frame
);
  localparam int VW = LANES*DATA_WIDTH;
  localparam int RW = ROWS*OUT_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int RI = $clog2(ROWS+1);
  state_t              state, state_d;
  logic [RI-1:0]       row_idx;
  logic [CW-1:0]       in_flight, fifo_count;
  logic [CW:0]         occ;
  logic [PIPE_LAT-1:0] pipe_v, pipe_l;
  logic                vec_last, hs, loading, last_row, accept, push, pop, credit_ok, fifo_empty;
  assign hs        = s_tvalid & s_tready;
  assign loading   = (state == IDLE) | (state == LOAD);
  assign last_row  = row_idx == RI'(ROWS-1);
  assign accept    = hs & (state == STREAM);
  assign push      = pipe_v[PIPE_LAT-1];
  assign pop       = m_tvalid & m_tready;
  assign m_tvalid  = ~fifo_empty;
  // every accepted vector owns a FIFO slot until it is pushed, so a push can never find the FIFO full
  assign occ       = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok = occ < (CW+1)'(FIFO_DEPTH);
  always_comb begin
    state_d  = state;
    s_tready = 1'b0;
    case (state)
      IDLE, LOAD: begin
        s_tready = 1'b1;
        if (s_tvalid) state_d = last_row ? (s_tlast ? DRAIN : STREAM) : (s_tlast ? IDLE : LOAD);
      end
      STREAM: begin
        s_tready = credit_ok;
        if (s_tvalid && credit_ok && s_tlast) state_d = DRAIN;
      end
      DRAIN: if (in_flight == '0 && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      row_idx        <= '0;
      in_flight      <= '0;
      core_load      <= 1'b0;
      core_vec_valid <= 1'b0;
      core_vec       <= '0;
      vec_last       <= 1'b0;
      err_frame      <= 1'b0;
      core_mat       <= '0;
      pipe_v         <= '0;
      pipe_l         <= '0;
    end else begin
      state          <= state_d;
      core_load      <= loading & hs & last_row;
      core_vec_valid <= accept;
      if (accept) begin
        core_vec <= s_tdata;
        vec_last <= s_tlast;
      end
      if (loading && hs) begin
        core_mat[int'(row_idx)*VW +: VW] <= s_tdata;
        row_idx <= (last_row || s_tlast) ? '0 : row_idx + RI'(1);
        if (s_tlast && !last_row) err_frame <= 1'b1;
      end
      in_flight <= in_flight + CW'(accept) - CW'(push);
      // valid/last ride alongside the core so they emerge with the matching core_res
      pipe_v <= {pipe_v[PIPE_LAT-2:0], core_vec_valid};
      pipe_l <= {pipe_l[PIPE_LAT-2:0], core_vec_valid & vec_last};
    end
  end
  sync_fifo #(
    .WIDTH(RW+1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .aresetn(aresetn),
    .push   (push),
    .din    ({pipe_l[PIPE_LAT-1], core_res}),
    .pop    (pop),
    .dout   ({m_tlast, m_tdata}),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_matvec_stream_ctrl.sv
// tb_matvec_stream_ctrl: directed bench with a behavioural core and an output scoreboard
module tb_matvec_stream_ctrl;
  import matvec_pkg::*;
  localparam int DW = 16, OW = 16, L = 4, R = 3, PL = 40, FD = 64;
  logic aclk = 1'b0;
  logic aresetn;
  logic [L*DW-1:0]   s_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic [R*OW-1:0]   m_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [R*L*DW-1:0] core_mat;
  logic              core_load, core_vec_valid, err_frame;
  logic [L*DW-1:0]   core_vec;
  logic [R*OW-1:0]   core_res;
  int checks = 0, errors = 0, rcvd = 0, rdy_mode = 0, r0;
  logic [R*OW:0] exp_q[$];
  logic [15:0]   bm[R][L];
  logic [R*OW-1:0] dl[PL];
  logic prev_stall = 1'b0;
  logic [R*OW:0] prev_d;
  always #5 aclk = ~aclk;
  matvec_stream_ctrl #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LANES(L), .ROWS(R), .PIPE_LAT(PL), .FIFO_DEPTH(FD)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .core_mat(core_mat), .core_load(core_load), .core_vec(core_vec),
    .core_vec_valid(core_vec_valid), .core_res(core_res), .err_frame(err_frame)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  function automatic logic [L*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction
  function automatic logic [L*DW-1:0] vec(input int i);
    return pk(i + 1, 2 * i, 3, i * 7 + 1);
  endfunction
  function automatic logic [R*OW:0] model(input logic l, input logic [L*DW-1:0] v);
    logic [R*OW:0] res;
    logic [15:0] s;
    res = '0;
    res[R*OW] = l;
    for (int r = 0; r < R; r++) begin
      s = '0;
      for (int c = 0; c < L; c++) s = s + bm[r][c] * v[c*DW +: DW];
      res[r*OW +: OW] = s;
    end
    return res;
  endfunction
  function automatic logic [R*OW-1:0] core_mv(input logic [R*L*DW-1:0] m, input logic [L*DW-1:0] v);
    logic [R*OW-1:0] res;
    logic [15:0] s;
    res = '0;
    for (int r = 0; r < R; r++) begin
      s = '0;
      for (int c = 0; c < L; c++) s = s + m[(r*L+c)*DW +: DW] * v[c*DW +: DW];
      res[r*OW +: OW] = s;
    end
    return res;
  endfunction
  always @(posedge aclk) begin
    dl[0] <= core_mv(core_mat, core_vec);
    for (int k = 1; k < PL; k++) dl[k] <= dl[k-1];
  end
  assign core_res = dl[PL-1];
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end
  always @(negedge aclk) begin
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_d});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_out", m_tvalid, 1'b0);
        else begin
          chk("out", {m_tlast, m_tdata}, exp_q.pop_front());
          rcvd++;
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_d = {m_tlast, m_tdata};
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic send_beat(input logic [L*DW-1:0] d, input logic l);
    logic got;
    got = 1'b0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge aclk);
      got = s_tready;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    chk("accept", got, 1'b1);
  endtask
  task automatic load_row(input int r, input logic [L*DW-1:0] d, input logic l);
    send_beat(d, l);
    for (int c = 0; c < L; c++) bm[r][c] = d[c*DW +: DW];
  endtask
  task automatic load_mat(input int seed);
    for (int r = 0; r < R; r++) load_row(r, pk(seed + 4*r, seed + 4*r + 1, seed + 4*r + 2, seed + 4*r + 3), 1'b0);
  endtask
  task automatic send_vec(input logic [L*DW-1:0] v, input logic l);
    send_beat(v, l);
    exp_q.push_back(model(l, v));
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20000 && !(exp_q.size() == 0 && dut.state == IDLE); i++) tick(1);
    chk("drain_q", exp_q.size(), 0);
    chk("idle", dut.state, IDLE);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    tick(2);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_core_load", core_load, 1'b0);
    chk("rst_core_vec_valid", core_vec_valid, 1'b0);
    chk("rst_err_frame", err_frame, 1'b0);
    chk("rst_core_mat", core_mat, '0);
    aresetn = 1'b1;
    rdy_mode = 1;
    tick(1);
    chk("idle_s_tready", s_tready, 1'b1);
    load_row(0, pk(1, 2, 3, 4), 1'b0);
    load_row(1, pk(5, 6, 7, 8), 1'b0);
    chk("core_load_early", core_load, 1'b0);
    load_row(2, pk(9, 10, 11, 12), 1'b0);
    chk("core_load_pulse", core_load, 1'b1);
    chk("core_mat", core_mat, {pk(9, 10, 11, 12), pk(5, 6, 7, 8), pk(1, 2, 3, 4)});
    send_beat(pk(1, 0, 0, 0), 1'b0);
    exp_q.push_back({1'b0, 16'd9, 16'd5, 16'd1});
    chk("core_load_single", core_load, 1'b0);
    chk("vec_valid", core_vec_valid, 1'b1);
    chk("core_vec", core_vec, pk(1, 0, 0, 0));
    send_beat(pk(0, 1, 0, 0), 1'b1);
    exp_q.push_back({1'b1, 16'd10, 16'd6, 16'd2});
    chk("drain_state", dut.state, DRAIN);
    tick(1);
    chk("vec_valid_low", core_vec_valid, 1'b0);
    wait_idle();
    load_mat(100);
    r0 = rcvd;
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) send_vec(vec(i), 1'b0);
    s_tdata = vec(64);
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    tick(60);
    chk("credit_stall", s_tready, 1'b0);
    chk("stall_m_tvalid", m_tvalid, 1'b1);
    rdy_mode = 1;
    for (int i = 64; i < 100; i++) send_vec(vec(i), i == 99);
    wait_idle();
    chk("t2_count", rcvd - r0, 100);
    load_row(0, pk(7, 7, 7, 7), 1'b0);
    load_row(1, pk(8, 8, 8, 8), 1'b1);
    chk("err_frame", err_frame, 1'b1);
    chk("err_state", dut.state, IDLE);
    chk("err_row_idx", dut.row_idx, 0);
    load_row(0, pk(2, 0, 1, 3), 1'b0);
    chk("row_after_err", dut.row_idx, 1);
    chk("row0_data", core_mat[L*DW-1:0], pk(2, 0, 1, 3));
    load_row(1, pk(1, 1, 1, 1), 1'b0);
    load_row(2, pk(4, 5, 6, 7), 1'b0);
    chk("err_core_load", core_load, 1'b1);
    chk("err_sticky", err_frame, 1'b1);
    for (int i = 0; i < 20; i++) send_vec(vec(i + 200), 1'b0);
    tick(5);
    chk("t4_in_flight", dut.in_flight, 20);
    chk("t4_no_out_yet", m_tvalid, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
    chk("mid_rst_err_frame", err_frame, 1'b0);
    chk("mid_rst_core_mat", core_mat, '0);
    chk("mid_rst_in_flight", dut.in_flight, 0);
    chk("mid_rst_state", dut.state, IDLE);
    exp_q.delete();
    tick(1);
    aresetn = 1'b1;
    chk("rel_s_tready", s_tready, 1'b1);
    r0 = rcvd;
    tick(80);
    chk("no_stale", m_tvalid, 1'b0);
    load_mat(300);
    for (int i = 0; i < 3; i++) send_vec(vec(i + 400), i == 2);
    wait_idle();
    chk("t4_count", rcvd - r0, 3);
    load_mat(500);
    rdy_mode = 2;
    r0 = rcvd;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 1) == 1) tick(1);
      send_vec(pk($urandom, $urandom, $urandom, $urandom), i == 999);
    end
    wait_idle();
    chk("t5_count", rcvd - r0, 1000);
    rdy_mode = 1;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
